cgra_col_pc_ctrl: RTL and testbench



---
 rtl/cgra_col_pc_ctrl_if.sv | 32 +++
 rtl/cgra_col_pc_ctrl.sv | 88 ++++++++
 tb/tb_cgra_col_pc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_col_pc_ctrl_if.sv
// Column PC sequencer bus: kernel launch, column feedback and the PC/strobe/status outputs.
// The slave side is the sequencer; the master side is whoever launches kernels and models the column.
interface cgra_col_pc_ctrl_if #(
   parameter int W  = 5,
   parameter int CW = 32
);
   logic          start_i;
   logic [W-1:0]  start_pc_i;
   logic          rcs_stall_i;
   logic          br_req_i;
   logic [W-1:0]  br_add_i;
   logic          exec_end_i;
   logic [W-1:0]  rcs_col_pc_o;
   logic          rcs_conf_re_o;
   logic          rcs_pc_e_o;
   logic          busy_o;
   logic          done_o;
   logic [CW-1:0] cycle_cnt_o;
   logic [CW-1:0] stall_cnt_o;

   modport slave (
      input  start_i, start_pc_i, rcs_stall_i, br_req_i, br_add_i, exec_end_i,
      output rcs_col_pc_o, rcs_conf_re_o, rcs_pc_e_o, busy_o, done_o,
             cycle_cnt_o, stall_cnt_o
   );

   modport master (
      output start_i, start_pc_i, rcs_stall_i, br_req_i, br_add_i, exec_end_i,
      input  rcs_col_pc_o, rcs_conf_re_o, rcs_pc_e_o, busy_o, done_o,
             cycle_cnt_o, stall_cnt_o
   );
endinterface

// File: rtl/cgra_col_pc_ctrl.sv
// Per-column program-counter sequencer: FETCH/EXEC loop with stall hold, branches,
// kernel-end detection and saturating busy/stall performance counters.
module cgra_col_pc_ctrl #(
   parameter int RCS_NUM_CREG_LOG2 = 5,
   parameter int CNT_WIDTH         = 32
) (
   input  logic clk_i,
   input  logic rst_col_i,
   cgra_col_pc_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_e                       state_q, state_d;
   logic [RCS_NUM_CREG_LOG2-1:0] pc_q, pc_d;
   logic [CNT_WIDTH-1:0]         cyc_q, cyc_d;
   logic [CNT_WIDTH-1:0]         stl_q, stl_d;
   logic                         commit;

   assign commit = (state_q == ST_EXEC) && !bus.rcs_stall_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cyc_d   = cyc_q;
      stl_d   = stl_q;
      if (state_q != ST_IDLE && cyc_q != CNT_MAX) begin
         cyc_d = cyc_q + 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_d = ST_FETCH;
               pc_d    = bus.start_pc_i;
               cyc_d   = '0;
               stl_d   = '0;
            end
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            if (!commit) begin
               if (stl_q != CNT_MAX) begin
                  stl_d = stl_q + 1'b1;
               end
            end else if (bus.br_req_i) begin
               // A branch outranks a simultaneous end: the kernel keeps running.
               pc_d    = bus.br_add_i;
               state_d = ST_FETCH;
            end else if (bus.exec_end_i) begin
               state_d = ST_DONE;
            end else begin
               pc_d    = pc_q + RCS_NUM_CREG_LOG2'(1);
               state_d = ST_FETCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_col_i) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cyc_q   <= '0;
         stl_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cyc_q   <= cyc_d;
         stl_q   <= stl_d;
      end
   end

   assign bus.rcs_col_pc_o  = pc_q;
   assign bus.rcs_conf_re_o = (state_q == ST_FETCH);
   assign bus.rcs_pc_e_o    = commit;
   assign bus.busy_o        = (state_q != ST_IDLE);
   assign bus.done_o        = (state_q == ST_DONE);
   assign bus.cycle_cnt_o   = cyc_q;
   assign bus.stall_cnt_o   = stl_q;
endmodule

// File: tb/tb_cgra_col_pc_ctrl.sv
// Scoreboard bench for cgra_col_pc_ctrl: a program-level model predicts fetches,
// commits, completion and counters; a negedge monitor pops and compares.
module tb_cgra_col_pc_ctrl;
   localparam int W  = 5;
   localparam int CW = 32;

   typedef struct {
      int stalls;
      bit br;
      int add;
      bit en;
   } instr_t;

   typedef struct {
      int pc;
      int t;
   } ev_t;

   typedef struct {
      int pc;
      int t;
      int cyc;
      int stl;
   } done_t;

   logic clk_i = 1'b0;
   logic rst_col_i = 1'b1;
   int   cyc_now = 0;

   cgra_col_pc_ctrl_if #(.W(W), .CW(CW)) cif ();

   cgra_col_pc_ctrl #(.RCS_NUM_CREG_LOG2(W), .CNT_WIDTH(CW)) dut (
      .clk_i     (clk_i),
      .rst_col_i (rst_col_i),
      .bus       (cif)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc_now <= cyc_now + 1;

   instr_t prog[$];
   ev_t    fetch_q[$];
   ev_t    commit_q[$];
   done_t  done_q[$];

   int nchk = 0;
   int nerr = 0;
   bit mon_en = 1'b0;
   int cur_pc = 0;
   int idle_pc = 0;
   int idle_cyc = 0;
   int idle_stl = 0;
   ev_t   mev;
   done_t mdone;

   task automatic chk(input string name, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc_now);
      end
   endtask

   task automatic qchk(input string name, input int sz);
      nchk++;
      if (sz == 0) begin
         nerr++;
         $display("FAIL %s: got unexpected event required none (cycle %0d)", name, cyc_now);
      end
   endtask

   // Monitor: everything sampled on the falling edge, away from the active edge.
   always @(negedge clk_i) begin
      if (mon_en) begin
         if (cif.rcs_conf_re_o) begin
            qchk("fetch_unexpected", fetch_q.size());
            if (fetch_q.size() != 0) begin
               mev = fetch_q.pop_front();
               chk("fetch_pc", longint'(cif.rcs_col_pc_o), mev.pc);
               chk("fetch_time", cyc_now, mev.t);
               cur_pc = mev.pc;
            end
         end
         if (cif.rcs_pc_e_o) begin
            qchk("commit_unexpected", commit_q.size());
            if (commit_q.size() != 0) begin
               mev = commit_q.pop_front();
               chk("commit_pc", longint'(cif.rcs_col_pc_o), mev.pc);
               chk("commit_time", cyc_now, mev.t);
               $display("commit pc=%0d cycle=%0d", mev.pc, cyc_now);
            end
         end
         if (cif.done_o) begin
            qchk("done_unexpected", done_q.size());
            if (done_q.size() != 0) begin
               mdone = done_q.pop_front();
               chk("done_pc", longint'(cif.rcs_col_pc_o), mdone.pc);
               chk("done_time", cyc_now, mdone.t);
               idle_pc  = mdone.pc;
               idle_cyc = mdone.cyc;
               idle_stl = mdone.stl;
               $display("done pc=%0d cycle=%0d exp_cyc_cnt=%0d exp_stall_cnt=%0d",
                        mdone.pc, cyc_now, mdone.cyc, mdone.stl);
            end
         end
         if (cif.busy_o && !cif.rcs_conf_re_o) begin
            chk("busy_pc_hold", longint'(cif.rcs_col_pc_o), cur_pc);
         end
         if (!cif.busy_o) begin
            chk("idle_pc", longint'(cif.rcs_col_pc_o), idle_pc);
            chk("idle_cycle_cnt", longint'(cif.cycle_cnt_o), idle_cyc);
            chk("idle_stall_cnt", longint'(cif.stall_cnt_o), idle_stl);
            chk("idle_strobes", longint'({cif.rcs_conf_re_o, cif.rcs_pc_e_o, cif.done_o}), 0);
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic junk(input bit busy_start);
      cif.br_req_i   = 1'($urandom);
      cif.exec_end_i = 1'($urandom);
      cif.br_add_i   = W'($urandom);
      cif.start_i    = busy_start ? 1'($urandom) : 1'b0;
      cif.start_pc_i = W'($urandom);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         junk(1'b0);
         cif.rcs_stall_i = 1'($urandom);
         step();
      end
   endtask

   // Launch the kernel in prog[] from the current IDLE cycle and push the
   // model's expected fetches, commits and completion.
   task automatic run_prog(input int spc);
      int  t;
      int  pc;
      int  cyc;
      int  stl;
      done_t d;
      junk(1'b0);
      cif.rcs_stall_i = 1'($urandom);
      cif.start_i     = 1'b1;
      cif.start_pc_i  = W'(spc);
      t   = cyc_now + 1;
      pc  = spc;
      cyc = 0;
      stl = 0;
      step();
      foreach (prog[k]) begin
         fetch_q.push_back('{pc: pc, t: t});
         cyc++;
         junk(1'b1);
         cif.rcs_stall_i = 1'($urandom);
         step();
         t++;
         for (int s = 0; s < prog[k].stalls; s++) begin
            junk(1'b1);
            cif.rcs_stall_i = 1'b1;
            step();
            t++;
            cyc++;
            stl++;
         end
         junk(1'b1);
         cif.rcs_stall_i = 1'b0;
         cif.br_req_i    = prog[k].br;
         cif.br_add_i    = W'(prog[k].add);
         cif.exec_end_i  = prog[k].en;
         commit_q.push_back('{pc: pc, t: t});
         cyc++;
         step();
         t++;
         if (prog[k].br) pc = prog[k].add;
         else if (prog[k].en) break;
         else pc = (pc + 1) % (1 << W);
      end
      d.pc  = pc;
      d.t   = t;
      d.cyc = cyc + 1;
      d.stl = stl;
      done_q.push_back(d);
      junk(1'b1);
      cif.rcs_stall_i = 1'($urandom);
      step();
      cif.start_i = 1'b0;
   endtask

   task automatic add_instr(input int stalls, input bit br, input int add, input bit en);
      prog.push_back('{stalls: stalls, br: br, add: add, en: en});
   endtask

   initial begin
      int n;
      cif.start_i     = 1'b0;
      cif.start_pc_i  = '0;
      cif.rcs_stall_i = 1'b0;
      cif.br_req_i    = 1'b0;
      cif.br_add_i    = '0;
      cif.exec_end_i  = 1'b0;
      rst_col_i       = 1'b1;
      step();
      mon_en = 1'b1;
      step();
      rst_col_i = 1'b0;
      idle_gap(2);

      // Linear kernel from PC 3, four instructions, no stalls.
      prog.delete();
      for (int i = 0; i < 4; i++) add_instr(0, 1'b0, 0, i == 3);
      run_prog(3);

      // Three stall cycles in the first EXEC, relaunched in the first IDLE cycle.
      prog.delete();
      add_instr(3, 1'b0, 0, 1'b0);
      add_instr(0, 1'b0, 0, 1'b1);
      run_prog(10);
      idle_gap(1);

      // Branch loop 0,1,0,1,0,1,2 with one combined branch/end commit.
      prog.delete();
      add_instr(0, 1'b0, 0, 1'b0);
      add_instr(0, 1'b1, 0, 1'b0);
      add_instr(1, 1'b0, 0, 1'b0);
      add_instr(0, 1'b1, 0, 1'b1);
      add_instr(0, 1'b0, 0, 1'b0);
      add_instr(2, 1'b0, 0, 1'b0);
      add_instr(0, 1'b0, 0, 1'b1);
      run_prog(0);
      idle_gap(2);

      // Wrap-around from the top address.
      prog.delete();
      add_instr(0, 1'b0, 0, 1'b0);
      add_instr(1, 1'b0, 0, 1'b1);
      run_prog(31);
      idle_gap(1);

      // Reset during a stalled EXEC cycle.
      junk(1'b0);
      cif.rcs_stall_i = 1'b0;
      cif.start_i     = 1'b1;
      cif.start_pc_i  = W'(9);
      fetch_q.push_back('{pc: 9, t: cyc_now + 1});
      step();
      junk(1'b1);
      step();
      junk(1'b1);
      cif.rcs_stall_i = 1'b1;
      rst_col_i       = 1'b1;
      step();
      idle_pc  = 0;
      idle_cyc = 0;
      idle_stl = 0;
      rst_col_i = 1'b0;
      idle_gap(3);

      // Randomized kernels.
      for (int r = 0; r < 40; r++) begin
         prog.delete();
         n = 1 + $urandom_range(0, 7);
         for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
               add_instr($urandom_range(0, 3), 1'b0, 0, 1'b1);
            end else begin
               bit b;
               b = ($urandom_range(0, 3) == 0);
               add_instr(($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                         b, $urandom_range(0, 31), b && ($urandom_range(0, 1) == 1));
            end
         end
         run_prog($urandom_range(0, 31));
         idle_gap($urandom_range(0, 2));
      end

      idle_gap(3);
      chk("fetch_q_leftover", fetch_q.size(), 0);
      chk("commit_q_leftover", commit_q.size(), 0);
      chk("done_q_leftover", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
